bread_program_sequencer: RTL
============================

Name: bread_program_sequencer

Overview:
Phase sequencer that drives the bread machine's shared heating element and paddle motor from a user-selected program.
- Supports three programs (basic, quick, dough) and an optional delayed start.
- Runs a one-clock-per-second timebase (1 Hz clk), consistent with the rest of the appliance.
- Provides the cancel, bell and status/display outputs used by the front panel.

Parameters:
KNEAD_S, 1200, basic-program knead duration in seconds (cycles)
RISE_S, 5400, basic-program rise duration in seconds
BAKE_S, 3000, basic-program bake duration in seconds
WARM_S, 3600, keep-warm duration after bake in seconds
DUTY_PERIOD, 4, heater duty period in RISE/WARM; heater on 1 cycle of every DUTY_PERIOD
TIMER_W, 16, phase timer width; every loaded value must be < 2**TIMER_W

Ports:
clk  input  1  1 Hz system clock, rising-edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start_button  input  1  synchronous level, sampled at posedge
cancel_button  input  1  synchronous level, sampled at posedge
program_sel  input  2  0 = basic, 1 = quick, 2 = dough, 3 = basic
delay_hours  input  4  delayed start, 0..12 h; values 13..15 clamp to 12
heating_element  output  1  heater drive
paddle_motor  output  1  paddle drive
bell  output  1  one-cycle completion pulse
busy  output  1  high in any state other than IDLE
phase  output  3  current state code
time_left  output  TIMER_W  cycles remaining in current phase, minus 1

Behaviour:
- State codes:
  - IDLE = 0, DELAY = 1, KNEAD = 2, RISE = 3, BAKE = 4, DONE = 5, WARM = 6.
  - State, timer, duty counter and latched program are registers.
  - Outputs are decoded from registers (no input-to-output combinational path).
- Reset: while rst = 0, all registers and outputs clear asynchronously, with state = IDLE and phase = 0. Reset mid-run aborts with no bell.
- Phase timing: entering a phase of duration D loads timer = D-1. The phase lasts exactly D cycles and exits on the posedge where timer == 0.
- Effective durations:
  - Basic: KNEAD_S, RISE_S, BAKE_S.
  - Quick: each value >> 1.
  - Dough: KNEAD_S, RISE_S, no BAKE, no WARM.
- IDLE, start = 1 and cancel = 0 at posedge:
  - Latch program_sel and the clamped delay value.
  - If delay is 0, go to KNEAD on the next cycle; otherwise go to DELAY with timer = delay*3600-1.
- DELAY: all drives off. Exits to KNEAD.
- KNEAD: paddle_motor = 1, heater 0. Exits to RISE.
- RISE:
  - Motor 0; heater = (duty_cnt == 0).
  - duty_cnt clears on phase entry and counts modulo DUTY_PERIOD, so the heater pattern is 1,0,0,0,1,...
  - Exits to BAKE, or to DONE for dough.
- BAKE: heating_element = 1 continuously, motor 0. Exits to DONE.
- DONE:
  - Lasts exactly 1 cycle with bell = 1 and drives off.
  - Then goes to WARM for basic/quick, or to IDLE for dough.
- WARM: heater uses the same duty pattern as RISE; duty_cnt clears on entry. Exits to IDLE with no second bell.
- Cancel:
  - cancel = 1 at posedge in any non-IDLE state → IDLE on the next cycle. All drives 0, bell 0, timer 0.
  - Cancel beats start in the same cycle.
- Ignored inputs:
  - start_button in any non-IDLE state is ignored.
  - program_sel and delay_hours changes after the latch are ignored until the next start.
- bell is never high for more than 1 consecutive cycle. heating_element and paddle_motor are never both 1.
- time_left = timer register; it is 0 in IDLE and DONE.

Decomposition:
- Package bread_pkg holds:
  - state codes (IDLE..WARM)
  - program codes (PROG_BASIC, PROG_QUICK, PROG_DOUGH)
  - SECS_PER_HOUR = 3600
  - MAX_DELAY_H = 12
- Sub-module phase_timer:
  - TIMER_W-bit down-counter with load/value inputs and a zero flag.
  - Holds at 0; load has priority over decrement; async active-low clear.
- All sequencing lives in bread_program_sequencer.

Test Plan:
1. Basic program, delay 0. Use KNEAD_S=8, RISE_S=12, BAKE_S=6, WARM_S=8, DUTY_PERIOD=4; start pulse at cycle 10 → motor high for cycles 11–18; RISE heater 1 at cycles 19, 23, 27; BAKE heater 31–36; bell only at 37; WARM heater at 38 and 42; phase = 0 at 46.
2. Quick and dough programs, same parameters:
   - Quick: phases of 4/6/3/8 cycles.
   - Dough: bell one cycle after RISE, then phase = 0 immediately, with heater never high for 2 consecutive cycles.
3. Delayed start: delay_hours = 1 → 3600 cycles with phase = 1, busy = 1 and all drives 0, then KNEAD. delay_hours = 15 → DELAY lasts 43200 cycles.
4. Cancel:
   - Cancel at RISE cycle 3 → next cycle phase = 0, drives 0, no bell ever.
   - Start and cancel in the same IDLE cycle → stays IDLE.
5. Ignored inputs: start pulse and program_sel = 2 during BAKE → no restart, program continues as basic including WARM.
6. Async reset: drive rst low mid-cycle during BAKE → heating_element, busy and phase drop to 0 before the next posedge. After release, IDLE with no bell.

Source files
------------

// File: rtl/bread_pkg.sv
// Shared types and constants for the bread machine program sequencer.
package bread_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    KNEAD = 3'd2,
    RISE  = 3'd3,
    BAKE  = 3'd4,
    DONE  = 3'd5,
    WARM  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PROG_BASIC = 2'd0,
    PROG_QUICK = 2'd1,
    PROG_DOUGH = 2'd2
  } prog_t;

  localparam int unsigned SECS_PER_HOUR = 3600;
  localparam int unsigned MAX_DELAY_H   = 12;

  // Selector code 3 is an alias for the basic program.
  function automatic prog_t decode_prog(input logic [1:0] sel);
    case (sel)
      2'd1:    return PROG_QUICK;
      2'd2:    return PROG_DOUGH;
      default: return PROG_BASIC;
    endcase
  endfunction

  function automatic int unsigned clamp_delay(input logic [3:0] hours);
    return (32'(hours) > MAX_DELAY_H) ? MAX_DELAY_H : 32'(hours);
  endfunction

endpackage

// File: rtl/bread_program_sequencer_phase_timer.sv
// Loadable down-counter that holds at zero; load wins over decrement.
module phase_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= value;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bread_program_sequencer.sv
// Phase sequencer driving heater and paddle motor for basic/quick/dough
// programs with optional delayed start; one clock per second.
module bread_program_sequencer
  import bread_pkg::*;
#(
  parameter int unsigned KNEAD_S     = 1200,
  parameter int unsigned RISE_S      = 5400,
  parameter int unsigned BAKE_S      = 3000,
  parameter int unsigned WARM_S      = 3600,
  parameter int unsigned DUTY_PERIOD = 4,
  parameter int unsigned TIMER_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_button,
  input  logic               cancel_button,
  input  logic [1:0]         program_sel,
  input  logic [3:0]         delay_hours,
  output logic               heating_element,
  output logic               paddle_motor,
  output logic               bell,
  output logic               busy,
  output logic [2:0]         phase,
  output logic [TIMER_W-1:0] time_left
);

  localparam int unsigned DUTY_W = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
  localparam logic [DUTY_W-1:0] DUTY_LAST = DUTY_W'(DUTY_PERIOD - 1);

  state_t              state, next_state;
  prog_t               prog_q, eff_prog;
  logic [DUTY_W-1:0]   duty_cnt;
  logic                tmr_load, tmr_zero, duty_clr, prog_latch;
  logic [TIMER_W-1:0]  tmr_value, tmr_count;
  logic [TIMER_W-1:0]  knead_ld, rise_ld, bake_ld, warm_ld, delay_ld;

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  // In IDLE the program is not latched yet, so look at the selector directly.
  assign eff_prog = (state == IDLE) ? decode_prog(program_sel) : prog_q;

  assign knead_ld = (eff_prog == PROG_QUICK) ? TIMER_W'((KNEAD_S >> 1) - 1) : TIMER_W'(KNEAD_S - 1);
  assign rise_ld  = (eff_prog == PROG_QUICK) ? TIMER_W'((RISE_S >> 1) - 1)  : TIMER_W'(RISE_S - 1);
  assign bake_ld  = (eff_prog == PROG_QUICK) ? TIMER_W'((BAKE_S >> 1) - 1)  : TIMER_W'(BAKE_S - 1);
  assign warm_ld  = TIMER_W'(WARM_S - 1);
  assign delay_ld = TIMER_W'(clamp_delay(delay_hours) * SECS_PER_HOUR - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prog_q   <= PROG_BASIC;
      duty_cnt <= '0;
    end else begin
      state <= next_state;
      if (prog_latch) prog_q <= decode_prog(program_sel);
      if (duty_clr)
        duty_cnt <= '0;
      else if (state == RISE || state == WARM)
        duty_cnt <= (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    duty_clr   = 1'b0;
    prog_latch = 1'b0;
    case (state)
      IDLE: if (start_button && !cancel_button) begin
        prog_latch = 1'b1;
        tmr_load   = 1'b1;
        if (clamp_delay(delay_hours) == 0) begin
          next_state = KNEAD;
          tmr_value  = knead_ld;
        end else begin
          next_state = DELAY;
          tmr_value  = delay_ld;
        end
      end
      DELAY: if (tmr_zero) begin
        next_state = KNEAD;
        tmr_load   = 1'b1;
        tmr_value  = knead_ld;
      end
      KNEAD: if (tmr_zero) begin
        next_state = RISE;
        tmr_load   = 1'b1;
        tmr_value  = rise_ld;
        duty_clr   = 1'b1;
      end
      RISE: if (tmr_zero) begin
        tmr_load = 1'b1;
        if (prog_q == PROG_DOUGH) begin
          next_state = DONE;
          tmr_value  = '0;
        end else begin
          next_state = BAKE;
          tmr_value  = bake_ld;
        end
      end
      BAKE: if (tmr_zero) begin
        next_state = DONE;
        tmr_load   = 1'b1;
        tmr_value  = '0;
      end
      DONE: begin
        if (prog_q == PROG_DOUGH) begin
          next_state = IDLE;
        end else begin
          next_state = WARM;
          tmr_load   = 1'b1;
          tmr_value  = warm_ld;
          duty_clr   = 1'b1;
        end
      end
      WARM: if (tmr_zero) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Cancel overrides every other transition once a program is running.
    if (state != IDLE && cancel_button) begin
      next_state = IDLE;
      tmr_load   = 1'b1;
      tmr_value  = '0;
      duty_clr   = 1'b1;
    end
  end

  assign paddle_motor    = (state == KNEAD);
  assign heating_element = (state == BAKE) ||
                           ((state == RISE || state == WARM) && duty_cnt == '0);
  assign bell            = (state == DONE);
  assign busy            = (state != IDLE);
  assign phase           = 3'(state);
  assign time_left       = tmr_count;

endmodule
